rggen_bus_arbiter: RTL and testbench
====================================

Name: rggen_bus_arbiter

Overview:
- Shares one downstream rggen_bus_if (normally feeding rggen_bus_splitter) between TOTAL_MASTERS upstream bus masters, e.g. a host CPU bridge and a debug port.
- Selects one requesting master by round-robin and forwards its access downstream, holding it until the downstream done pulse.
- Routes done/read_done/write_done, read_data and status back to the granted master only.
- Exactly one access is outstanding downstream at any time.

Parameters:
- ADDRESS_WIDTH, 16, width of address field on all bus interfaces
- DATA_WIDTH, 32, width of read_data/write_data; multiple of 8
- TOTAL_MASTERS, 2, number of upstream masters; >= 1

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- master_if[TOTAL_MASTERS]  rggen_bus_if.slave  -  upstream masters (request, address, direction, write_data, write_strobe in; done, read_done, write_done, read_data, status out)
- bus_if  rggen_bus_if.master  -  downstream bus toward the splitter
- grant  output  TOTAL_MASTERS  one-hot current owner; 0 when idle

Behaviour:
- Reset values: state=IDLE, grant=0, rr pointer=0, bus_if.request=0.
  - All master_if done/read_done/write_done=0, read_data=0, status=RGGEN_OKAY.
- State machine:
  - IDLE: if any master_if[i].request, pick the first requester at or after pointer, wrapping modulo TOTAL_MASTERS. Register one-hot grant and go to BUSY. No requests: stay in IDLE, grant=0.
  - BUSY: bus_if.request=1. address, direction, write_data and write_strobe are muxed combinationally from the granted master.
  - BUSY exit: on bus_if.done=1, go to IDLE, clear grant, and set pointer=(granted index+1) mod TOTAL_MASTERS.
- Latency: master request to downstream request is 1 cycle (the arbitration cycle). done returns to the master combinationally, in the same cycle as bus_if.done.
- Response routing: granted master gets bus_if.done, read_done, write_done, read_data and status unchanged. All other masters see done=0 and read_data=0; status=RGGEN_OKAY.
- After done, state is IDLE for at least one cycle and bus_if.request=0. This prevents the splitter re-issuing the same access.
  - A master holding request high after its done is treated as a new access.
  - It is arbitrated with round-robin fairness, so other waiting masters go first.
- Protocol: a master must hold request and all request fields stable until it sees done.
  - If a granted master drops request mid-access, the arbiter stays BUSY and keeps bus_if.request=1 until bus_if.done. The access completes and its response is driven to that master.
- Simultaneous requests: exactly one grant; the others wait with done=0.
- TOTAL_MASTERS=1: pointer is constant 0; latency and behaviour are otherwise unchanged.
- Reset mid-access: everything returns to reset values immediately (asynchronous), and the in-flight response is dropped.
- Pointer width is $clog2(TOTAL_MASTERS), minimum 1 bit. Wrap uses explicit compare to TOTAL_MASTERS-1, not power-of-two overflow.

Decomposition:
- rggen_rtl_pkg: rggen_direction (RGGEN_READ/RGGEN_WRITE) and rggen_status (RGGEN_OKAY, RGGEN_SLAVE_ERROR, ...). Add a two-value arbiter state enum (IDLE/BUSY) there.
- Sub-module rggen_round_robin_selector:
  - Parameter N.
  - Inputs: request[N], pointer.
  - Output: one-hot select[N].
  - Purely combinational; the pointer register stays in the arbiter.

Test Plan:
- Single read: master 0 reads address 0x0010; splitter returns data 0xDEADBEEF with RGGEN_OKAY, done 3 cycles after bus_if.request.
  - bus_if.request rises 1 cycle after master request.
  - master_if[0].done/read_done=1 with 0xDEADBEEF in the same cycle as bus_if.done.
  - master_if[1].done=0; grant returns to 0.
- Simultaneous requests (TOTAL_MASTERS=3, all request at cycle 0, pointer=0), each master holding request until its done:
  - Grants in order 0, 1, 2, each separated by at least one IDLE cycle with bus_if.request=0.
  - Afterwards pointer=0.
- Fairness: master 0 requests continuously while master 1 requests once. Grant sequence is 0, 1, 0, 0; master 1 waits at most one access.
- Error passthrough: master 1 writes unmapped address 0x00FC with write_strobe=4'b0011.
  - Downstream write_data and write_strobe equal master 1's values.
  - Downstream returns RGGEN_SLAVE_ERROR; master_if[1] gets write_done=1 and status=RGGEN_SLAVE_ERROR.
  - master_if[0].status=RGGEN_OKAY.
- Reset mid-access: assert rst while BUSY, before done.
  - Same cycle: bus_if.request=0, grant=0, all master done=0.
  - After rst release with master 1 requesting: master 1 granted (pointer=0, master 0 idle).
- Request drop: granted master 0 drops request while BUSY.
  - bus_if.request stays 1 until bus_if.done.
  - master_if[0].done pulses once, then IDLE.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-bus fabric: transfer direction, response
// status, arbiter state and a pointer-width helper.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } rggen_arbiter_state;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int rggen_ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus: one request with its fields towards the slave, a single-cycle
// done pulse with read data and status back towards the master.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  import rggen_rtl_pkg::*;

  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  logic                      read_done;
  logic                      write_done;
  logic [DATA_WIDTH-1:0]     read_data;
  rggen_status               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_done, write_done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_done, write_done, read_data, status
  );

endinterface

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping past N-1 back to 0. Result is one-hot or all zero.
module rggen_round_robin_selector
  import rggen_rtl_pkg::*;
#(
  parameter  int N     = 2,
  localparam int PTR_W = rggen_ptr_width(N)
)(
  input  logic [N-1:0]     request_i,
  input  logic [PTR_W-1:0] pointer_i,
  output logic [N-1:0]     select_o
);

  // Scan the N candidates in priority order starting from the pointer.
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    select_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(pointer_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && request_i[PTR_W'(idx)]) begin
        select_o[PTR_W'(idx)] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one downstream register bus between TOTAL_MASTERS upstream masters.
// A round-robin pick is registered in an arbitration cycle, the winner's
// access is forwarded until the downstream done pulse, and the response is
// routed back to the winner only. One IDLE cycle always separates accesses so
// a master still holding request is re-arbitrated as a fresh access.
module rggen_bus_arbiter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TOTAL_MASTERS = 2
)(
  input  logic                     clk,
  input  logic                     rst,
  rggen_bus_if.slave               master_if [TOTAL_MASTERS],
  rggen_bus_if.master              bus_if,
  output logic [TOTAL_MASTERS-1:0] grant
);

  localparam int PTR_W  = rggen_ptr_width(TOTAL_MASTERS);
  localparam int STRB_W = DATA_WIDTH / 8;

  rggen_arbiter_state       state_q, state_d;
  logic [TOTAL_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;

  logic [TOTAL_MASTERS-1:0] request_vec;
  logic [TOTAL_MASTERS-1:0] select;
  logic [ADDRESS_WIDTH-1:0] address_arr      [TOTAL_MASTERS];
  rggen_direction           direction_arr    [TOTAL_MASTERS];
  logic [DATA_WIDTH-1:0]    write_data_arr   [TOTAL_MASTERS];
  logic [STRB_W-1:0]        write_strobe_arr [TOTAL_MASTERS];

  logic [PTR_W-1:0]         granted_idx;
  logic [PTR_W-1:0]         next_ptr;

  logic [ADDRESS_WIDTH-1:0] address_mux;
  rggen_direction           direction_mux;
  logic [DATA_WIDTH-1:0]    write_data_mux;
  logic [STRB_W-1:0]        write_strobe_mux;

  // Flatten the interface array into plain vectors and gate each response
  // with that master's grant bit, so non-owners see an idle, OKAY bus.
  for (genvar i = 0; i < TOTAL_MASTERS; i++) begin : g_master
    assign request_vec[i]      = master_if[i].request;
    assign address_arr[i]      = master_if[i].address;
    assign direction_arr[i]    = master_if[i].direction;
    assign write_data_arr[i]   = master_if[i].write_data;
    assign write_strobe_arr[i] = master_if[i].write_strobe;

    assign master_if[i].done       = grant_q[i] & bus_if.done;
    assign master_if[i].read_done  = grant_q[i] & bus_if.read_done;
    assign master_if[i].write_done = grant_q[i] & bus_if.write_done;
    assign master_if[i].read_data  = grant_q[i] ? bus_if.read_data : '0;
    assign master_if[i].status     = grant_q[i] ? bus_if.status : RGGEN_OKAY;
  end

  rggen_round_robin_selector #(
    .N (TOTAL_MASTERS)
  ) u_selector (
    .request_i (request_vec),
    .pointer_i (ptr_q),
    .select_o  (select)
  );

  // Encode the one-hot owner so the pointer can advance past it.
  always_comb begin
    granted_idx = '0;
    for (int i = 0; i < TOTAL_MASTERS; i++) begin
      if (grant_q[i]) begin
        granted_idx = PTR_W'(i);
      end
    end
  end

  // Explicit wrap: TOTAL_MASTERS need not be a power of two.
  assign next_ptr = (granted_idx == PTR_W'(TOTAL_MASTERS - 1)) ? '0
                                                               : granted_idx + PTR_W'(1);

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Arbitrate in IDLE, hold the owner in BUSY until downstream done.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        grant_d = '0;
        if (|request_vec) begin
          state_d = ARB_BUSY;
          grant_d = select;
        end
      end
      ARB_BUSY: begin
        if (bus_if.done) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = next_ptr;
        end
      end
    endcase
  end

  // Forward the owner's request fields; all zero when nobody owns the bus.
  always_comb begin
    address_mux      = '0;
    direction_mux    = RGGEN_READ;
    write_data_mux   = '0;
    write_strobe_mux = '0;
    for (int i = 0; i < TOTAL_MASTERS; i++) begin
      if (grant_q[i]) begin
        address_mux      = address_arr[i];
        direction_mux    = direction_arr[i];
        write_data_mux   = write_data_arr[i];
        write_strobe_mux = write_strobe_arr[i];
      end
    end
  end

  assign bus_if.request      = (state_q == ARB_BUSY);
  assign bus_if.address      = address_mux;
  assign bus_if.direction    = direction_mux;
  assign bus_if.write_data   = write_data_mux;
  assign bus_if.write_strobe = write_strobe_mux;

  assign grant = grant_q;

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter with three masters and a behavioural
// downstream responder that answers after a programmable number of cycles.
module tb_rggen_bus_arbiter;
  import rggen_rtl_pkg::*;

  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [NM-1:0] grant;

  logic           m_req    [NM];
  logic [AW-1:0]  m_addr   [NM];
  rggen_direction m_dir    [NM];
  logic [DW-1:0]  m_wdata  [NM];
  logic [DW/8-1:0] m_strb  [NM];
  logic           m_done   [NM];
  logic           m_rdone  [NM];
  logic           m_wdone  [NM];
  logic [DW-1:0]  m_rdata  [NM];
  rggen_status    m_status [NM];

  logic        s_done, s_rdone, s_wdone;
  logic [DW-1:0] s_rdata;
  rggen_status s_status;

  int          resp_delay;
  int          resp_cnt;
  logic [DW-1:0] resp_data;
  rggen_status resp_status;

  int n_compared;
  int n_mismatched;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) m_if [NM] ();
  rggen_bus_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  for (genvar g = 0; g < NM; g++) begin : g_tb_master
    assign m_if[g].request      = m_req[g];
    assign m_if[g].address      = m_addr[g];
    assign m_if[g].direction    = m_dir[g];
    assign m_if[g].write_data   = m_wdata[g];
    assign m_if[g].write_strobe = m_strb[g];
    assign m_done[g]   = m_if[g].done;
    assign m_rdone[g]  = m_if[g].read_done;
    assign m_wdone[g]  = m_if[g].write_done;
    assign m_rdata[g]  = m_if[g].read_data;
    assign m_status[g] = m_if[g].status;
  end

  assign bus_if.done       = s_done;
  assign bus_if.read_done  = s_rdone;
  assign bus_if.write_done = s_wdone;
  assign bus_if.read_data  = s_rdata;
  assign bus_if.status     = s_status;

  rggen_bus_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TOTAL_MASTERS (NM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .master_if (m_if),
    .bus_if    (bus_if),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus_request(input string tag);
    int n;
    n = 0;
    while (!bus_if.request && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus_if.request, 1'b1);
  endtask

  task automatic wait_bus_done(input string tag, output int cycles);
    cycles = 0;
    while (!bus_if.done && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, bus_if.done, 1'b1);
  endtask

  task automatic resp_idle();
    s_done   = 1'b0;
    s_rdone  = 1'b0;
    s_wdone  = 1'b0;
    s_rdata  = '0;
    s_status = RGGEN_OKAY;
    resp_cnt = 0;
  endtask

  // Downstream responder: done rises resp_delay cycles after request rose.
  initial begin
    resp_idle();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        resp_idle();
      end else begin
        #1;
        if (s_done) begin
          resp_idle();
        end else if (bus_if.request) begin
          resp_cnt++;
          if (resp_cnt > resp_delay) begin
            s_done   = 1'b1;
            s_rdone  = (bus_if.direction == RGGEN_READ);
            s_wdone  = (bus_if.direction == RGGEN_WRITE);
            s_rdata  = (bus_if.direction == RGGEN_READ) ? resp_data : '0;
            s_status = resp_status;
          end
        end else begin
          resp_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int fair_seq [4] = '{0, 1, 0, 0};

  initial begin
    int          cyc;
    int          pulses;
    int          n;
    logic [NM-1:0] exp_vec;
    logic [NM-1:0] done_vec;

    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    resp_delay   = 3;
    resp_data    = '0;
    resp_status  = RGGEN_OKAY;
    for (int i = 0; i < NM; i++) begin
      m_req[i]   = 1'b0;
      m_addr[i]  = '0;
      m_dir[i]   = RGGEN_READ;
      m_wdata[i] = '0;
      m_strb[i]  = '0;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 3'b000);
    check("rst_bus_req", bus_if.request, 1'b0);
    for (int i = 0; i < NM; i++) begin
      check($sformatf("rst_done%0d", i), m_done[i], 1'b0);
      check($sformatf("rst_rdata%0d", i), m_rdata[i], '0);
      check($sformatf("rst_status%0d", i), m_status[i], RGGEN_OKAY);
    end
    tick();
    rst = 1'b0;

    // Simultaneous requests from pointer 0: grants 0, 1, 2 with IDLE gaps.
    resp_delay = 1;
    resp_data  = 32'hA5A5_0000;
    tick();
    for (int i = 0; i < NM; i++) begin
      m_addr[i] = AW'(16'h0100 + 4 * i);
      m_req[i]  = 1'b1;
    end
    for (int k = 0; k < NM; k++) begin
      exp_vec = 3'b001 << k;
      wait_bus_request($sformatf("sim_req_seen%0d", k));
      check($sformatf("sim_addr%0d", k), bus_if.address, AW'(16'h0100 + 4 * k));
      wait_bus_done($sformatf("sim_done_seen%0d", k), cyc);
      done_vec = {m_done[2], m_done[1], m_done[0]};
      check($sformatf("sim_grant%0d", k), grant, exp_vec);
      check($sformatf("sim_done_vec%0d", k), done_vec, exp_vec);
      tick();
      for (int i = 0; i < NM; i++) if (done_vec[i]) m_req[i] = 1'b0;
      @(negedge clk);
      check($sformatf("sim_gap_req%0d", k), bus_if.request, 1'b0);
      check($sformatf("sim_gap_grant%0d", k), grant, 3'b000);
    end

    // Fairness: master 0 requests continuously, master 1 once.
    tick();
    m_req[0] = 1'b1;
    m_req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_vec = 3'b001 << fair_seq[k];
      wait_bus_done($sformatf("fair_done_seen%0d", k), cyc);
      done_vec = {m_done[2], m_done[1], m_done[0]};
      check($sformatf("fair_grant%0d", k), grant, exp_vec);
      check($sformatf("fair_done_vec%0d", k), done_vec, exp_vec);
      tick();
      if (done_vec[1]) m_req[1] = 1'b0;
      if (k == 3) m_req[0] = 1'b0;
      @(negedge clk);
      check($sformatf("fair_gap_req%0d", k), bus_if.request, 1'b0);
    end

    // Single read by master 0.
    resp_delay = 3;
    resp_data  = 32'hDEAD_BEEF;
    tick();
    m_addr[0] = 16'h0010;
    m_dir[0]  = RGGEN_READ;
    m_req[0]  = 1'b1;
    @(negedge clk);
    check("rd_arb_cycle_req", bus_if.request, 1'b0);
    @(negedge clk);
    check("rd_bus_req", bus_if.request, 1'b1);
    check("rd_grant", grant, 3'b001);
    check("rd_addr", bus_if.address, 16'h0010);
    check("rd_dir", bus_if.direction, RGGEN_READ);
    wait_bus_done("rd_done_seen", cyc);
    check("rd_latency", cyc, 3);
    check("rd_m0_done", m_done[0], 1'b1);
    check("rd_m0_read_done", m_rdone[0], 1'b1);
    check("rd_m0_rdata", m_rdata[0], 32'hDEAD_BEEF);
    check("rd_m0_status", m_status[0], RGGEN_OKAY);
    check("rd_m1_done", m_done[1], 1'b0);
    check("rd_m1_rdata", m_rdata[1], '0);
    tick();
    m_req[0] = 1'b0;
    @(negedge clk);
    check("rd_grant_idle", grant, 3'b000);
    check("rd_req_idle", bus_if.request, 1'b0);

    // Write to an unmapped address with an error response.
    resp_delay  = 2;
    resp_status = RGGEN_SLAVE_ERROR;
    tick();
    m_wdata[0] = 32'hFFFF_FFFF;
    m_strb[0]  = 4'hF;
    m_addr[1]  = 16'h00FC;
    m_dir[1]   = RGGEN_WRITE;
    m_wdata[1] = 32'h1234_5678;
    m_strb[1]  = 4'b0011;
    m_req[1]   = 1'b1;
    wait_bus_request("err_req_seen");
    check("err_grant", grant, 3'b010);
    check("err_addr", bus_if.address, 16'h00FC);
    check("err_dir", bus_if.direction, RGGEN_WRITE);
    check("err_wdata", bus_if.write_data, 32'h1234_5678);
    check("err_strobe", bus_if.write_strobe, 4'b0011);
    wait_bus_done("err_done_seen", cyc);
    check("err_m1_write_done", m_wdone[1], 1'b1);
    check("err_m1_read_done", m_rdone[1], 1'b0);
    check("err_m1_status", m_status[1], RGGEN_SLAVE_ERROR);
    check("err_m0_status", m_status[0], RGGEN_OKAY);
    check("err_m0_done", m_done[0], 1'b0);
    tick();
    m_req[1]    = 1'b0;
    resp_status = RGGEN_OKAY;

    // Reset in the middle of an access.
    resp_delay = 8;
    tick();
    m_dir[0] = RGGEN_READ;
    m_req[0] = 1'b1;
    wait_bus_request("rst_mid_req_seen");
    check("rst_mid_grant_busy", grant, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_bus_req", bus_if.request, 1'b0);
    check("rst_mid_grant", grant, 3'b000);
    check("rst_mid_done_vec", {m_done[2], m_done[1], m_done[0]}, 3'b000);
    m_req[0]   = 1'b0;
    m_dir[1]   = RGGEN_READ;
    m_req[1]   = 1'b1;
    resp_delay = 1;
    @(negedge clk);
    rst = 1'b0;
    wait_bus_request("rst_after_req_seen");
    check("rst_after_grant", grant, 3'b010);
    wait_bus_done("rst_after_done_seen", cyc);
    check("rst_after_m1_done", m_done[1], 1'b1);
    tick();
    m_req[1] = 1'b0;

    // Granted master drops request mid-access.
    resp_delay = 4;
    resp_data  = 32'h0BAD_F00D;
    tick();
    m_req[0] = 1'b1;
    wait_bus_request("drop_req_seen");
    tick();
    m_req[0] = 1'b0;
    n = 0;
    while (!bus_if.done && n < 50) begin
      check($sformatf("drop_req_held%0d", n), bus_if.request, 1'b1);
      @(negedge clk);
      n++;
    end
    check("drop_done_seen", bus_if.done, 1'b1);
    check("drop_m0_done", m_done[0], 1'b1);
    check("drop_m0_rdata", m_rdata[0], 32'h0BAD_F00D);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(m_done[0]);
    end
    check("drop_extra_done", pulses, 0);
    check("drop_grant_idle", grant, 3'b000);
    check("drop_req_idle", bus_if.request, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
